// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite codes and the slave state enum.
package ahbl_pkg;
   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ = 2'b11;
   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;
   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
endpackage

// File: rtl/ahbl_byte_lane_dec.sv
// ahbl_byte_lane_dec: byte-lane enables and misalignment flag from HSIZE and addr[1:0].
module ahbl_byte_lane_dec
   import ahbl_pkg::*;
(
   input logic [2:0] size,
   input logic [1:0] addr,
   output logic [3:0] be,
   output logic misaligned
);
   always_comb begin
      be = size == HSIZE_BYTE ? 4'b0001 << addr :
           size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
           size == HSIZE_WORD ? 4'b1111 : 4'b0000;
      misaligned = (size == HSIZE_HALF && addr[0]) || (size == HSIZE_WORD && addr != 2'b00);
   end
endmodule

// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave: AHB-Lite slave driving a single-port synchronous SRAM.
// Define AHBL_SRAM_ALIGN_ERR_EN to answer misaligned transfers with ERROR.
module ahbl_sram_slave
   import ahbl_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int WAIT_STATES = 1
) (
   input logic HCLK,
   input logic HRESET,
   input logic HSEL,
   input logic [31:0] HADDR,
   input logic [1:0] HTRANS,
   input logic HWRITE,
   input logic [2:0] HSIZE,
   input logic [2:0] HBURST,
   input logic [31:0] HWDATA,
   input logic HREADYIN,
   output logic HREADYOUT,
   output logic HRESP,
   output logic [31:0] HRDATA,
   output logic [ADDR_WIDTH-3:0] MEM_ADDR,
   output logic MEM_WE,
   output logic MEM_RE,
   output logic [3:0] MEM_BE,
   output logic [31:0] MEM_WDATA,
   input logic [31:0] MEM_RDATA
);
   state_t state;
   logic [2:0] cnt;
   logic wr;
   logic [3:0] be;
   logic mis, sample, bad, go;
   logic unused;
   ahbl_byte_lane_dec u_dec (.size(HSIZE), .addr(HADDR[1:0]), .be(be), .misaligned(mis));
   always_comb begin
      HREADYOUT = state == DATA ? cnt == 3'd0 : state != ERR1;
      HRESP = state == ERR1 || state == ERR2;
      HRDATA = state == DATA && cnt == 3'd0 && !wr ? MEM_RDATA : 32'd0;
      MEM_WDATA = HWDATA;
      sample = HSEL && HREADYIN && HREADYOUT && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
`ifdef AHBL_SRAM_ALIGN_ERR_EN
      bad = HSIZE > HSIZE_WORD || mis;
`else
      bad = HSIZE > HSIZE_WORD;
`endif
      go = sample && !bad;
   end
`ifdef AHBL_SRAM_ALIGN_ERR_EN
   assign unused = ^{HBURST, HADDR[31:ADDR_WIDTH]};
`else
   assign unused = ^{HBURST, HADDR[31:ADDR_WIDTH], mis};
`endif
   // A new address phase is only taken in a ready cycle: IDLE, last DATA cycle or ERR2.
   always_ff @(posedge HCLK or posedge HRESET)
      if (HRESET) begin
         state <= IDLE;
         cnt <= 3'd0;
         wr <= 1'b0;
         MEM_WE <= 1'b0;
         MEM_RE <= 1'b0;
         MEM_BE <= 4'd0;
         MEM_ADDR <= '0;
      end else begin
         MEM_WE <= go && HWRITE;
         MEM_RE <= go && !HWRITE;
         if (state == ERR1)
            state <= ERR2;
         else if (state == DATA && cnt != 3'd0)
            cnt <= cnt - 3'd1;
         else begin
            state <= sample ? (bad ? ERR1 : DATA) : IDLE;
            cnt <= go ? 3'(WAIT_STATES) : 3'd0;
            if (go) begin
               wr <= HWRITE;
               MEM_ADDR <= HADDR[ADDR_WIDTH-1:2];
               MEM_BE <= be;
            end
         end
      end
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb_ahbl_sram_slave: random AHB-Lite traffic checked cycle by cycle against a transfer-level model.
module tb_ahbl_sram_slave;
   import ahbl_pkg::*;
   localparam int AW = 12;
   localparam int WS = 3;
   logic HCLK = 0, HRESET = 1, HSEL = 0, HWRITE = 0;
   logic [31:0] HADDR = 0, HWDATA = 0;
   logic [1:0] HTRANS = 0;
   logic [2:0] HSIZE = 0, HBURST = 0;
   logic HREADYIN, HREADYOUT, HRESP, MEM_WE, MEM_RE;
   logic [31:0] HRDATA, MEM_WDATA;
   bit [31:0] MEM_RDATA;
   logic [AW-3:0] MEM_ADDR;
   logic [3:0] MEM_BE;
   assign HREADYIN = HREADYOUT;
   always #5 HCLK = ~HCLK;
   ahbl_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .MEM_ADDR(MEM_ADDR),
      .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
   );
   // SRAM attached to the slave: one-cycle read latency, byte-enabled writes
   bit [31:0] sram [0:1023];
   always @(posedge HCLK) begin
      if (MEM_WE === 1'b1)
         for (int i = 0; i < 4; i++)
            if (MEM_BE[i]) sram[MEM_ADDR][8*i+:8] <= MEM_WDATA[8*i+:8];
      if (MEM_RE === 1'b1) MEM_RDATA <= sram[MEM_ADDR];
   end
   typedef struct {
      bit ready, resp, we, re, rd;
      bit [31:0] rdata, wdata;
      bit [9:0] addr;
      bit [3:0] be;
   } exp_t;
   exp_t q[$];
   exp_t cur;
   bit [31:0] shadow [0:1023];
   bit [31:0] a_data;
   int cyc = 0;
   int total = 0, passed = 0, we_n = 0, re_n = 0, low_n = 0, err_n = 0;
   int re_cyc_prev = 0, re_cyc_last = 0;
   bit [31:0] last_rd;
   bit [3:0] last_we_be;
   bit [9:0] last_addr;
   int b, l, e, r;
   function automatic exp_t idle_rec();
      exp_t x = '{default: 0};
      x.ready = 1;
      return x;
   endfunction
   function automatic void chk(string n, logic [31:0] g, logic [31:0] x);
      total++;
      if (g === x) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", n, g, x, $time);
   endfunction
   // Model: each sampled transfer expands into its expected per-cycle response list.
   task automatic model_update();
      bit was = cur.ready;
      int nb, w;
      bit bad;
      bit [3:0] be;
      exp_t x;
      cyc++;
      if (q.size() != 0) void'(q.pop_front());
      if (HRESET) q.delete();
      else if (was && HSEL && HTRANS[1]) begin
         nb = 1 << HSIZE;
         w = (HADDR % (1 << AW)) / 4;
         bad = HSIZE > 2;
`ifdef AHBL_SRAM_ALIGN_ERR_EN
         bad = bad || (HADDR % nb != 0);
`endif
         if (bad) begin
            x = '{default: 0};
            x.resp = 1;
            q.push_back(x);
            x.ready = 1;
            q.push_back(x);
         end else begin
            be = 4'((1 << nb) - 1) << (HADDR[1:0] / nb * nb);
            for (int i = 0; i <= WS; i++) begin
               x = '{default: 0};
               x.ready = (i == WS);
               if (i == 0) begin
                  x.we = HWRITE; x.re = !HWRITE; x.addr = 10'(w); x.be = be; x.wdata = a_data;
               end
               if (i == WS && !HWRITE) begin
                  x.rd = 1; x.rdata = shadow[w];
               end
               q.push_back(x);
            end
            if (HWRITE) begin
               for (int i = 0; i < 4; i++)
                  if (be[i]) shadow[w][8*i+:8] = a_data[8*i+:8];
               HWDATA = a_data;
            end
         end
      end
      cur = q.size() != 0 ? q[0] : idle_rec();
   endtask
   task automatic step();
      @(posedge HCLK);
      #1;
      model_update();
   endtask
   task automatic ahb(bit sel, bit [1:0] tr, bit wr, bit [2:0] sz, bit [31:0] ad, bit [31:0] d);
      while (!cur.ready) step();
      HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = ad; a_data = d;
      HBURST = 3'($urandom);
      step();
   endtask
   task automatic idle(int n);
      repeat (n) begin
         if (cur.ready) begin
            HTRANS = HTRANS_IDLE; HSEL = 0;
         end
         step();
      end
   endtask
   always @(negedge HCLK) begin
      chk("hreadyout", 32'(HREADYOUT), 32'(cur.ready));
      chk("hresp", 32'(HRESP), 32'(cur.resp));
      chk("hrdata", HRDATA, cur.rdata);
      chk("mem_we", 32'(MEM_WE), 32'(cur.we));
      chk("mem_re", 32'(MEM_RE), 32'(cur.re));
      if (cur.we || cur.re) begin
         chk("mem_addr", 32'(MEM_ADDR), 32'(cur.addr));
         chk("mem_be", 32'(MEM_BE), 32'(cur.be));
      end
      if (cur.we) chk("mem_wdata", MEM_WDATA, cur.wdata);
      if (HRESET) begin
         chk("rst_addr", 32'(MEM_ADDR), 0);
         chk("rst_be", 32'(MEM_BE), 0);
      end
      if (MEM_WE === 1'b1) begin we_n++; last_we_be = MEM_BE; last_addr = MEM_ADDR; end
      if (MEM_RE === 1'b1) begin re_n++; last_addr = MEM_ADDR; re_cyc_prev = re_cyc_last; re_cyc_last = cyc; end
      if (HREADYOUT === 1'b0) low_n++;
      if (HRESP === 1'b1) err_n++;
      if (cur.rd) last_rd = HRDATA;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      cur = idle_rec();
      HRESET = 1;
      step(); step();
      HRESET = 0;
      idle(2);
      b = we_n; l = low_n;
      ahb(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
      idle(WS + 2);
      chk("word_we_pulses", we_n - b, 1);
      chk("word_mem_addr", 32'(last_addr), 4);
      chk("word_mem_be", 32'(last_we_be), 32'hF);
      chk("word_wait_cycles", low_n - l, WS);
      chk("word_sram", sram[4], 32'hDEADBEEF);
      ahb(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h13, 32'hAA000000);
      ahb(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
      idle(WS + 2);
      chk("byte_mem_be", 32'(last_we_be), 32'h8);
      chk("byte_readback", last_rd, 32'hAAADBEEF);
      r = re_n; l = low_n;
      ahb(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0);
      ahb(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h4, 32'h0);
      idle(WS + 2);
      chk("b2b_re_pulses", re_n - r, 2);
      chk("b2b_wait_cycles", low_n - l, 2 * WS);
      chk("b2b_strobe_spacing", re_cyc_last - re_cyc_prev, WS + 1);
      b = we_n; e = err_n;
      ahb(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h2, 32'h12345678);
      idle(WS + 2);
`ifdef AHBL_SRAM_ALIGN_ERR_EN
      chk("misalign_err_cycles", err_n - e, 2);
      chk("misalign_we_pulses", we_n - b, 0);
`else
      chk("misalign_err_cycles", err_n - e, 0);
      chk("misalign_we_pulses", we_n - b, 1);
      chk("misalign_mem_addr", 32'(last_addr), 0);
`endif
      b = we_n; e = err_n;
      ahb(1, HTRANS_NONSEQ, 1, 3'd3, 32'h20, 32'h55555555);
      idle(4);
      chk("size3_err_cycles", err_n - e, 2);
      chk("size3_we_pulses", we_n - b, 0);
      ahb(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0);
      step();
      HRESET = 1; HTRANS = HTRANS_IDLE; HSEL = 0;
      q.delete();
      cur = idle_rec();
      #1;
      chk("rst_async_ready", 32'(HREADYOUT), 1);
      chk("rst_async_re", 32'(MEM_RE), 0);
      step();
      HRESET = 0;
      r = re_n;
      idle(5);
      chk("rst_no_late_re", re_n - r, 0);
      ahb(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h4, 32'h0);
      idle(WS + 2);
      chk("rst_new_read", re_n - r, 1);
      repeat (400) begin
         int n = $urandom_range(0, 9);
         int t = $urandom_range(0, 9);
         if (n == 0) idle($urandom_range(1, 3));
         else ahb($urandom_range(0, 9) != 0,
                  t < 2 ? 2'(t) : {1'b1, 1'($urandom)},
                  1'($urandom),
                  $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2)),
                  ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                  $urandom);
      end
      idle(WS + 3);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Downstream AHB-Lite slave. It consumes the 32-bit AHB-Lite master bus produced by the AXI-to-AHB-Lite bridge and drives a single-port synchronous SRAM.

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: SRAM byte-address width; word address is ADDR_WIDTH-2 bits.
REQ-002 SHALL have parameter WAIT_STATES, default 1, legal range 1..7: extra data-phase cycles per transfer.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock. One clock; reset is asynchronous and active-high.
REQ-004 SHALL have port HRESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port HSEL, input, 1 bit: slave select from the decoder.
REQ-006 SHALL have port HADDR, input, 32 bits: address; bits above ADDR_WIDTH are ignored (aliasing).
REQ-007 SHALL have ports HTRANS, input, 2 bits; HWRITE, input, 1 bit; HSIZE, input, 3 bits; HBURST, input, 3 bits. HBURST is ignored.
REQ-008 SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-009 SHALL have port HREADYIN, input, 1 bit: bus-wide ready.
REQ-010 SHALL have ports HREADYOUT, output, 1 bit; HRESP, output, 1 bit; HRDATA, output, 32 bits.
REQ-011 SHALL have ports MEM_ADDR, output, ADDR_WIDTH-2 bits; MEM_WE, output, 1 bit; MEM_RE, output, 1 bit; MEM_BE, output, 4 bits; MEM_WDATA, output, 32 bits.
REQ-012 SHALL have port MEM_RDATA, input, 32 bits: valid one cycle after MEM_RE and held until the next MEM_RE.

Function
REQ-013 SHALL sample an address phase only when HSEL=1, HREADYIN=1 and HTRANS is NONSEQ or SEQ. On sampling, it registers the address, HWRITE and HSIZE.
REQ-014 SHALL answer IDLE, BUSY or unselected transfers with a zero-wait OKAY and perform no SRAM access.
REQ-015 SHALL use state machine states IDLE, DATA, ERR1 and ERR2.
- IDLE->DATA on a valid sample.
- IDLE->ERR1 on an illegal sample.
- DATA->IDLE, DATA, or ERR1 in the last data cycle, according to the next sample.
- ERR1->ERR2 unconditionally.
- ERR2->IDLE, DATA, or ERR1, according to the next sample.
REQ-016 SHALL make each legal data phase exactly WAIT_STATES+1 cycles long. HREADYOUT=0 for the first WAIT_STATES cycles and HREADYOUT=1 in the last cycle, tracked by a 3-bit down-counter.
REQ-017 SHALL pulse MEM_WE (write) or MEM_RE (read) for exactly one cycle, the first data-phase cycle.
- MEM_ADDR comes from the registered address.
- MEM_WDATA=HWDATA.
- MEM_WE and MEM_RE are never both high.
REQ-018 SHALL drive HRDATA=MEM_RDATA during the last cycle of a read data phase, and 0 otherwise.
REQ-019 SHALL derive MEM_BE from the registered HSIZE and address bits [1:0].
- Byte: one lane, 1<<addr[1:0].
- Halfword: 4'b0011 or 4'b1100, selected by addr[1].
- Word: 4'b1111.
REQ-020 SHALL treat HSIZE>2 as illegal in all builds.
REQ-021 SHALL give an illegal transfer a two-cycle ERROR response.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- No MEM_WE or MEM_RE for that transfer.
REQ-022 SHALL accept a back-to-back address phase presented during the last data cycle or ERR2 with no idle cycle inserted.
REQ-023 SHALL hold HRESP=0 at all times outside ERR1 and ERR2.

Reset
REQ-024 SHALL, while HRESET=1, force:
- state IDLE, counter 0;
- HREADYOUT=1, HRESP=0, HRDATA=0;
- MEM_WE=0, MEM_RE=0, MEM_BE=0, MEM_ADDR=0.
REQ-025 SHALL, on reset mid-transfer, abandon the transfer without issuing a late SRAM strobe. The first legal sample after reset release proceeds normally.

Configuration
REQ-026 SHALL, with macro AHBL_SRAM_ALIGN_ERR_EN defined, treat misaligned transfers as illegal (ERROR, no access). Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]!=0.
REQ-027 SHALL, with AHBL_SRAM_ALIGN_ERR_EN undefined, force low address bits to alignment and complete misaligned transfers as OKAY.

Structure
REQ-028 SHALL put the following in a shared package, ahbl_pkg:
- HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
- HSIZE codes;
- the state enum.
REQ-029 SHALL use a single sub-module, ahbl_byte_lane_dec. It takes HSIZE and addr[1:0] and produces MEM_BE[3:0] and a misaligned flag.

Verification
REQ-030 Word write, WAIT_STATES=1: HADDR=0x10, data 0xDEADBEEF. Required: MEM_WE pulse with MEM_ADDR=4 and MEM_BE=4'b1111; HREADYOUT low for 1 cycle; HRESP=0.
REQ-031 Byte write then word read: write 0xAA at 0x13, then read 0x10. Required: MEM_BE=4'b1000; HRDATA bits [31:24]=0xAA in the last read cycle.
REQ-032 Back-to-back NONSEQ reads of 0x0 and 0x4 with WAIT_STATES=3. Required: each data phase is 4 cycles; exactly two MEM_RE pulses; no gap cycle between transfers.
REQ-033 Word access at 0x2. With AHBL_SRAM_ALIGN_ERR_EN defined: ERR1/ERR2 sequence and no strobe. Without it: OKAY with MEM_ADDR=0.
REQ-034 HSIZE=3 write: two-cycle ERROR response and no MEM_WE.
REQ-035 HRESET asserted in the 2nd cycle of a WAIT_STATES=3 read. Required: immediate reset values; no MEM_RE after release until a new NONSEQ is sampled.
